// File: rtl/rate_div_pipeline.sv
// rate_div_pipeline
// Multi-rate capture/decode pipeline on a single clock. A free-running
// capture register samples every cycle; a programmable divider produces a
// clock enable that advances the synch -> decode -> output stages. The
// output stage presents results on a valid/ready handshake and flags
// dropped results with a sticky overflow bit.
module rate_div_pipeline #(
    parameter int WIDTH  = 4,
    parameter int DIV_W  = 4,
    parameter bit INVERT = 1'b1
) (
    input  logic             fast_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic [1:0]       mode,
    input  logic             out_ready,
    input  logic             overflow_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overflow
);

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_REV  = 2'd2;

    // Decode function applied between the synch and decode stages.
    function automatic logic [WIDTH-1:0] decode_f(input logic [WIDTH-1:0] x,
                                                  input logic [1:0]       m);
        logic [WIDTH-1:0] r;
        r = '0;
        case (m)
            MODE_PASS: r = x;
            MODE_GRAY: r = x ^ (x >> 1);
            MODE_REV: begin
                for (int i = 0; i < WIDTH; i++) begin
                    r[i] = x[WIDTH-1-i];
                end
            end
            default: begin
                // popcount never exceeds WIDTH, which fits in WIDTH bits for WIDTH >= 2
                for (int i = 0; i < WIDTH; i++) begin
                    r = r + WIDTH'(x[i]);
                end
            end
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] shift_q,  shift_d;
    logic             v_shift_q, v_shift_d;
    logic [WIDTH-1:0] synch_q,  synch_d;
    logic             v_s_q,    v_s_d;
    logic [WIDTH-1:0] decode_q, decode_d;
    logic             v_d_q,    v_d_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q,    ovf_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    logic             en;
    logic             transfer;
    logic             load_ok;
    logic             drop;
    logic [WIDTH-1:0] out_value;

    // Divider enable compares against the live ratio so a lowered ratio
    // takes effect on the very next edge instead of finishing the old count.
    assign en = (div_cnt_q >= div_ratio);

    // Divider counter: restart on enable, otherwise count up.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (en) begin
            div_cnt_d = '0;
        end
    end

    // Capture stage runs every cycle; its valid bit becomes 1 on the first edge.
    always_comb begin
        shift_d   = data;
        v_shift_d = 1'b1;
    end

    // Enable-gated synch and decode stages; mode is sampled at the decode edge.
    always_comb begin
        synch_d  = synch_q;
        v_s_d    = v_s_q;
        decode_d = decode_q;
        v_d_d    = v_d_q;
        if (en) begin
            synch_d  = shift_q;
            v_s_d    = v_shift_q;
            decode_d = decode_f(synch_q, mode);
            v_d_d    = v_s_q;
        end
    end

    assign out_value = INVERT ? ~decode_q : decode_q;
    assign transfer  = out_valid_q & out_ready;
    assign load_ok   = ~out_valid_q | transfer;
    assign drop      = en & v_d_q & ~load_ok;

    // Output handshake: load when the slot is free or being drained this edge,
    // otherwise drop the result and hold out_data; overflow set beats clear.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        if (transfer) begin
            out_valid_d = 1'b0;
        end
        if (en && v_d_q && load_ok) begin
            out_data_d  = out_value;
            out_valid_d = 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end
    end

    // All state registers share one async reset so a reset mid-stream
    // discards every in-flight sample at once.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            v_shift_q   <= 1'b0;
            synch_q     <= '0;
            v_s_q       <= 1'b0;
            decode_q    <= '0;
            v_d_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            div_cnt_q   <= '0;
        end else begin
            shift_q     <= shift_d;
            v_shift_q   <= v_shift_d;
            synch_q     <= synch_d;
            v_s_q       <= v_s_d;
            decode_q    <= decode_d;
            v_d_q       <= v_d_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            div_cnt_q   <= div_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_rate_div_pipeline.sv
// Directed bench for rate_div_pipeline (WIDTH=4, DIV_W=4, INVERT=1).
module tb_rate_div_pipeline;

    logic       fast_clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data = '0;
    logic [3:0] div_ratio = '0;
    logic [1:0] mode = '0;
    logic       out_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    rate_div_pipeline #(.WIDTH(4), .DIV_W(4), .INVERT(1'b1)) dut (
        .fast_clk     (fast_clk),
        .rst          (rst),
        .data         (data),
        .div_ratio    (div_ratio),
        .mode         (mode),
        .out_ready    (out_ready),
        .overflow_clr (overflow_clr),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .overflow     (overflow)
    );

    always #5 fast_clk = ~fast_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock edge, then sample 1 time unit later
    task automatic step(input int n);
        repeat (n) begin
            @(posedge fast_clk);
            #1;
        end
    endtask

    // reset, released at a falling edge so the next rising edge is edge 1
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge fast_clk);
        @(negedge fast_clk);
        rst = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 0);

        // ---------------- 1: div 0, pass, A -> 5 after edge 4 ----------------
        rst = 1'b1; #1;
        div_ratio = 0; mode = 0; data = 4'hA; out_ready = 1;
        do_reset();
        step(3);
        chk("t1_valid_e3", out_valid, 0);
        step(1);
        chk("t1_valid_e4", out_valid, 1);
        chk("t1_data_e4", out_data, 4'h5);

        // ---------------- 2: div 3 -> en at edges 4,8,12 ----------------
        rst = 1'b1; #1;
        div_ratio = 3;
        do_reset();
        step(11);
        chk("t2_valid_e11", out_valid, 0);
        step(1);
        chk("t2_valid_e12", out_valid, 1);
        chk("t2_data_e12", out_data, 4'h5);
        data = 4'h0;
        step(3);
        chk("t2_hold_e15", out_data, 4'h5);
        // 0 entered shift at e13; synch e16, decode e20, out e24 -> ~0 = F
        step(8);
        chk("t2_hold_e23", out_data, 4'h5);
        step(1);
        chk("t2_upd_e24", out_data, 4'hF);

        // ---------------- 3: decode modes ----------------
        rst = 1'b1; #1;
        div_ratio = 0; mode = 1; data = 4'b0110;
        do_reset();
        step(4);
        chk("t3_gray", out_data, 4'b1010);
        mode = 3; data = 4'hF;
        step(4);
        chk("t3_popcnt", out_data, 4'b1011);
        mode = 2; data = 4'b0001;
        step(4);
        chk("t3_rev", out_data, 4'b0111);

        // ---------------- 4: backpressure and overflow ----------------
        rst = 1'b1; #1;
        div_ratio = 0; mode = 0; data = 4'hA; out_ready = 0;
        do_reset();
        step(4);
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, 4'h5);
        chk("t4_ovf0", overflow, 0);
        data = 4'h3;
        step(1);
        chk("t4_ovf_set", overflow, 1);
        chk("t4_held", out_data, 4'h5);
        overflow_clr = 1;
        step(1);
        chk("t4_set_wins", overflow, 1);
        out_ready = 1;
        step(1);
        chk("t4_clr", overflow, 0);
        chk("t4_valid_xfer", out_valid, 1);
        overflow_clr = 0;
        step(1);
        chk("t4_newdata", out_data, 4'hC);

        // ---------------- 5: div 7 -> 1 mid-count ----------------
        rst = 1'b1; #1;
        div_ratio = 7; mode = 0; out_ready = 1;
        do_reset();
        for (int n = 1; n <= 42; n++) begin
            data = 4'(n);
            if (n == 38) div_ratio = 1;   // div_cnt is 5 here
            step(1);
            if (n == 23) chk("t5_valid_e23", out_valid, 0);
            if (n == 24) chk("t5_e24", out_data, 4'h8);
            if (n == 32) chk("t5_e32", out_data, 4'h0);
            if (n == 37) chk("t5_e37", out_data, 4'h0);
            if (n == 38) chk("t5_e38", out_data, 4'h8);
            if (n == 39) chk("t5_e39", out_data, 4'h8);
            if (n == 40) chk("t5_e40", out_data, 4'h0);
            if (n == 41) chk("t5_e41", out_data, 4'h0);
            if (n == 42) chk("t5_e42", out_data, 4'hA);
        end

        // ---------------- 6: async reset mid-stream ----------------
        div_ratio = 0; data = 4'hA; out_ready = 0;
        step(3);
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_ovf", overflow, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_data", out_data, 0);
        out_ready = 1;
        do_reset();
        step(3);
        chk("t6_refill_e3", out_valid, 0);
        step(1);
        chk("t6_refill_e4", out_valid, 1);
        chk("t6_refill_data", out_data, 4'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // bound total run time
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
